bin2bcd_dd: RTL and testbench
=============================

// Module: bin2bcd_dd
// PURPOSE
//   Sequential binary-to-BCD converter (shift-and-add-3 / double dabble).
//   Upstream stage of the BCD-to-excess-3 converter: takes an unsigned
//   binary word and produces packed BCD digits, one digit per 4-bit nibble.
//   A start/busy/done handshake lets a controller request a conversion and
//   collect the result. One conversion step is performed per clock.
// PARAMETERS
//   WIDTH   8  bit width of the binary input
//   DIGITS  3  number of BCD output digits; must satisfy 10**DIGITS > 2**WIDTH-1
// PORTS
//   clk    in   1          clock, all state changes on rising edge
//   rst    in   1          reset, synchronous, active-high
//   start  in   1          conversion request, sampled only in IDLE
//   bin    in   WIDTH      binary operand, captured on the accepted start edge
//   busy   out  1          high while a conversion is in progress
//   done   out  1          one-cycle pulse: bcd holds a new valid result
//   bcd    out  4*DIGITS   packed BCD result; digit 0 (units) in bcd[3:0]
// BEHAVIOUR
//   Reset: rst=1 at a rising edge -> state IDLE, busy=0, done=0, bcd=0,
//     internal shift/scratch registers and step counter cleared.
//     rst has priority over every other input, including mid-conversion;
//     an aborted conversion produces no done pulse and leaves bcd=0.
//   States: IDLE, SHIFT.
//   IDLE: busy=0. Edge with start=1 -> capture bin into the shift register,
//     clear the BCD scratch register, step count=0, go to SHIFT, busy=1.
//     start=0 -> remain in IDLE.
//   SHIFT: busy=1. Each edge performs one step on {scratch, shift}:
//     (a) every scratch digit >= 5 has 3 added (4-bit, no carry out);
//     (b) the combined register shifts left by 1; the MSB of shift enters
//         the LSB of scratch. Step count increments.
//     The edge that performs step WIDTH loads bcd with the final scratch
//     value, sets done=1 and busy=0, and returns to IDLE.
//   Latency: start accepted at edge N -> done=1 and bcd valid after edge
//     N+WIDTH (8 cycles at the default). Throughput: one result per WIDTH+1
//     cycles, because start is sampled in IDLE only.
//   done is high for exactly one cycle and low otherwise.
//   bcd updates only on the completion edge (or reset) and holds its value
//     between conversions; intermediate scratch values are never visible.
//   start while busy=1 is ignored and not queued. Changes on bin after the
//     accepting edge do not affect the running conversion.
//   start=1 during the done cycle (state already IDLE) is accepted; this
//     back-to-back case is legal.
//   Every output nibble is always a legal BCD digit 0..9, so bcd can drive
//     the excess-3 stage directly, one nibble per converter.
// TESTING
//   1. bin=0, start pulse -> done 8 cycles later, bcd=12'h000, busy high 8 cycles.
//   2. bin=255 -> bcd=12'h255 (0010_0101_0101); bin=99 -> bcd=12'h099.
//   3. bin=100, start held high 3 cycles into SHIFT with bin changed to 7
//      -> single conversion, bcd=12'h100, exactly one done pulse.
//   4. bin=200 accepted, rst=1 at the 4th SHIFT edge -> busy=0, done never
//      pulses, bcd=0; next start with bin=42 -> bcd=12'h042.
//   5. back-to-back: start re-asserted in the done cycle with bin=13 after
//      bin=250 -> bcd=12'h250, then 9 cycles later bcd=12'h013.
//   6. exhaustive sweep bin=0..255 -> each nibble equals (bin/10**i)%10,
//      every nibble <=9, done latency always 8.

Source files
------------

// File: rtl/bin2bcd_dd.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// One conversion step runs per clock. A conversion takes WIDTH steps after
// the start edge. The result is presented as packed BCD digits.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset; overrides every other input
//   start  conversion request, sampled only while idle
//   bin    unsigned binary operand, captured on the accepting start edge
//   busy   high while a conversion is in progress
//   done   one-cycle pulse when bcd holds a new result
//   bcd    packed BCD result, digit 0 (units) in bcd[3:0]
module bin2bcd_dd #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned BcdW = 4 * DIGITS;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [BcdW-1:0]     scratch_q, scratch_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [BcdW-1:0]     bcd_q, bcd_d;
  logic                done_q, done_d;

  // Datapath for one double-dabble step.
  logic [BcdW-1:0]       adj;
  logic [BcdW+WIDTH-1:0] stepped;

  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    // The MSB of the shift register moves into the LSB of the scratch.
    stepped = {adj, shift_q} << 1;
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          shift_d   = bin;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        shift_d   = stepped[WIDTH-1:0];
        scratch_d = stepped[BcdW+WIDTH-1:WIDTH];
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          bcd_d   = stepped[BcdW+WIDTH-1:WIDTH];
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q == StShift);
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_dd.sv
// Directed self-checking bench for bin2bcd_dd (WIDTH=8, DIGITS=3).
module tb_bin2bcd_dd;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  int n_tests;
  int n_fail;

  bin2bcd_dd #(
    .WIDTH  (8),
    .DIGITS (3)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done, counting edges and busy samples before it. Bounded.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc      = 0;
    busy_cnt = 0;
    while (!done && cyc < 20) begin
      busy_cnt += int'(busy);
      tick();
      cyc++;
    end
  endtask

  // Starts a conversion from idle and checks latency, busy and result.
  task automatic run_conv(input logic [7:0] b, input logic [11:0] exp_bcd, input string tag);
    int cyc;
    int bc;
    bin   = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    check_eq({tag, "_done_low"}, 32'(done), 32'd0);
    wait_done(cyc, bc);
    check_eq({tag, "_latency"}, 32'(cyc), 32'd8);
    check_eq({tag, "_busy_cycles"}, 32'(bc), 32'd8);
    check_eq({tag, "_bcd"}, 32'(bcd), 32'(exp_bcd));
    check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc;
    int bc;
    int dn;
    int lat;
    logic [11:0] got;
    logic [11:0] exp_w;

    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    bin     = 8'd0;
    tick();
    tick();
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_bcd", 32'(bcd), 32'd0);
    rst = 1'b0;
    tick();

    // 1. Zero operand.
    run_conv(8'd0, 12'h000, "zero");

    // 2. Max and a two-digit value.
    tick();
    run_conv(8'd255, 12'h255, "max");
    tick();
    run_conv(8'd99, 12'h099, "ninety_nine");
    tick();

    // 3. Start held for three SHIFT edges while bin changes.
    bin   = 8'd100;
    start = 1'b1;
    tick();
    bin = 8'd7;
    dn  = 0;
    lat = 0;
    got = '0;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) start = 1'b0;
      tick();
      if (done) begin
        dn++;
        got = bcd;
        lat = i + 1;
      end
    end
    check_eq("held_start_pulses", 32'(dn), 32'd1);
    check_eq("held_start_bcd", 32'(got), 32'h100);
    check_eq("held_start_latency", 32'(lat), 32'd8);
    check_eq("held_start_bcd_holds", 32'(bcd), 32'h100);

    // 4. Reset at the 4th SHIFT edge aborts the conversion.
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    bin   = 8'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_bcd", 32'(bcd), 32'd0);
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) dn++;
    end
    check_eq("abort_no_done", 32'(dn), 32'd0);
    check_eq("abort_bcd_after", 32'(bcd), 32'd0);
    run_conv(8'd42, 12'h042, "after_abort");
    tick();

    // 5. Back-to-back: restart during the done cycle.
    bin   = 8'd250;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc, bc);
    check_eq("b2b_first_latency", 32'(cyc), 32'd8);
    check_eq("b2b_first_bcd", 32'(bcd), 32'h250);
    bin   = 8'd13;
    start = 1'b1;
    tick();
    start = 1'b0;
    bin   = 8'd0;
    check_eq("b2b_accepted", 32'(busy), 32'd1);
    check_eq("b2b_bcd_held", 32'(bcd), 32'h250);
    wait_done(cyc, bc);
    check_eq("b2b_gap", 32'(cyc + 1), 32'd9);
    check_eq("b2b_second_bcd", 32'(bcd), 32'h013);
    tick();

    // 6. Exhaustive sweep, back-to-back through run_conv.
    for (int b = 0; b < 256; b++) begin
      exp_w = {4'(b / 100), 4'((b / 10) % 10), 4'(b % 10)};
      run_conv(8'(b), exp_w, $sformatf("sweep_%0d", b));
      for (int i = 0; i < 3; i++) begin
        check_eq($sformatf("sweep_%0d_nib%0d_le9", b, i), 32'(bcd[4*i +: 4] <= 4'd9), 32'd1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
